fnd_seg_capture: RTL and testbench
==================================

// Module: fnd_seg_capture
// PURPOSE
//   Receive side of the 6-digit multiplexed FND interface (o_com/o_seg/o_dp). It watches a
//   scanned display bus, captures each digit once that digit's select and pattern are stable,
//   and reverse-decodes the 7-seg pattern to a 4-bit code. It then presents the complete
//   6-digit frame on a valid/ready handshake. Used for display loopback checking and for
//   reading external FND drivers.
// PARAMETERS
//   STABLE_CNT   4   consecutive identical input-register cycles required before capture (>=2)
//   COM_ACT_LOW  0   1: a com line is selected when 0; 0: selected when 1
//   SEG_ACT_LOW  0   1: invert i_seg/i_dp before decoding
// PORTS
//   clk        in   1   system clock, all logic on rising edge
//   rst_n      in   1   synchronous reset, active-low
//   i_com      in   6   digit select, bit k = digit k
//   i_seg      in   7   segments {a,b,c,d,e,f,g}, bit6 = a
//   i_dp       in   1   decimal point
//   o_digits   out  24  frame; o_digits[4k+3:4k] = code of digit k
//   o_dp       out  6   captured dp per digit
//   o_bad      out  6   bit k = 1: digit k pattern not in decode table
//   o_valid    out  1   frame available
//   i_ready    in   1   consumer accepts frame when o_valid & i_ready
//   o_overrun  out  1   sticky: a frame was overwritten before acceptance
// BEHAVIOUR
//   - Reset (rst_n=0 at an edge): every output is 0. Input regs, counter and seen[5:0] are
//     cleared; the FSM goes to SETTLE. Reset mid-frame discards partial digits.
//   - Input stage: {com,seg,dp} registered once after polarity normalisation (1 cycle).
//     Only the registered copy is used from here on.
//   - sel_ok = normalised com is exactly one-hot. All-zero or multi-hot is never captured.
//   - FSM SETTLE:
//       * If the reg equals its previous value and sel_ok: cnt++, saturating.
//       * Otherwise: cnt=0.
//       * When cnt reaches STABLE_CNT-1 and the value is still equal, on that edge: capture
//         into slot k, set seen[k], go to HOLD.
//       * Net: capture occurs on the STABLE_CNT-th consecutive cycle of an identical
//         registered value.
//   - FSM HOLD: stay while the reg is unchanged. Any change -> cnt=0, go to SETTLE.
//     Result: one capture per stable period.
//   - Re-capturing a digit before the frame completes overwrites its slot; seen[k] stays 1.
//   - Decode table (seg -> code):
//       1111110->0  0110000->1  1101101->2  1111001->3  0110011->4  1011011->5
//       1011111->6  1110000->7  1111111->8  1110011->9  1110111->A  1001110->C
//       1001111->E  1000111->F
//   - 1111111 always decodes to 8 and 1111110 always to 0; B and D are not distinguishable.
//   - Any other pattern: code 0 and bad flag 1 for that slot.
//   - Frame complete: the edge on which seen becomes 6'b111111. On the next edge:
//       * o_digits, o_dp and o_bad load from the slots;
//       * o_valid = 1;
//       * seen is cleared. Slots keep their values until overwritten.
//   - Handshake: o_valid & i_ready at an edge -> o_valid=0 and o_overrun=0 next cycle.
//     o_digits, o_dp and o_bad hold their last values.
//   - A new frame loads while o_valid=1 & i_ready=0: outputs take the new frame, o_valid
//     stays 1, o_overrun=1.
//   - A new frame loads in the same cycle as a handshake: new data, o_valid stays 1,
//     o_overrun=0.
//   - Outputs change only on a frame load or a handshake; they are never combinational
//     from the inputs.
// TESTING (STABLE_CNT=4, active-high unless stated)
//   1 rst_n=0 for 2 cycles with random inputs -> all outputs 0; rst_n=1, idle bus -> o_valid
//     stays 0.
//   2 com=000001..100000 with seg for 1,2,3,4,5,6, each held 8 cycles -> o_valid=1,
//     o_digits=24'h654321, o_bad=0, exactly 6 captures.
//   3 Digit 2: seg toggles every 2 cycles for 20 cycles, then held 8 cycles -> single capture
//     of the final value; no capture during toggling; boundary case 3 equal cycles -> none,
//     4 -> one.
//   4 com=6'b010101 or 6'b000000 held 50 cycles -> seen unchanged, o_valid=0; COM_ACT_LOW=1
//     with com=111110 -> digit 0 captured.
//   5 Digit 3 seg=0000001, rest valid -> o_bad=6'b001000, o_digits[15:12]=0; seg 1011111
//     with dp=1 -> code 6, o_dp bit set.
//   6 Two full frames with i_ready=0 -> second frame on outputs, o_overrun=1; one-cycle
//     i_ready=1 -> o_valid=0, o_overrun=0; rst_n=0 after 3 digits then full frame -> only
//     the post-reset frame appears.

Source files
------------

// File: rtl/fnd_seg_capture.sv
// Receive side of a 6-digit multiplexed FND bus: captures each digit once its select and
// pattern are stable, reverse-decodes the 7-seg pattern and hands frames out on valid/ready.
module fnd_seg_capture #(
  parameter int unsigned STABLE_CNT  = 4,
  parameter bit          COM_ACT_LOW = 1'b0,
  parameter bit          SEG_ACT_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  i_com,
  input  logic [6:0]  i_seg,
  input  logic        i_dp,
  output logic [23:0] o_digits,
  output logic [5:0]  o_dp,
  output logic [5:0]  o_bad,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_overrun
);

  localparam int unsigned NDIG   = 6;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned CNT_W  = $clog2(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CNT - 2);

  typedef enum logic {SETTLE = 1'b0, HOLD = 1'b1} state_t;

  logic [NDIG-1:0]   com_n_c;
  logic [SEG_W-1:0]  seg_n_c;
  logic              dp_n_c;
  logic [NDIG-1:0]   com_q, com_p;
  logic [SEG_W-1:0]  seg_q, seg_p;
  logic              dp_q, dp_p;
  logic              same_c, sel_ok_c, cap_c, load_c, hs_c;
  logic [IDX_W-1:0]  idx_c;
  logic [CODE_W:0]   dec_c;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  state_t            state_q, state_d;
  logic [CODE_W-1:0] slot_code [NDIG];
  logic [NDIG-1:0]   slot_dp, slot_bad, seen;
  logic [NDIG*CODE_W-1:0] frame_c;

  // Returns {bad, code}; B and D are indistinguishable from 8 and 0 so they never appear.
  function automatic logic [CODE_W:0] decode7(input logic [SEG_W-1:0] s);
    logic [CODE_W:0] d;
    case (s)
      7'b1111110: d = {1'b0, 4'h0};
      7'b0110000: d = {1'b0, 4'h1};
      7'b1101101: d = {1'b0, 4'h2};
      7'b1111001: d = {1'b0, 4'h3};
      7'b0110011: d = {1'b0, 4'h4};
      7'b1011011: d = {1'b0, 4'h5};
      7'b1011111: d = {1'b0, 4'h6};
      7'b1110000: d = {1'b0, 4'h7};
      7'b1111111: d = {1'b0, 4'h8};
      7'b1110011: d = {1'b0, 4'h9};
      7'b1110111: d = {1'b0, 4'hA};
      7'b1001110: d = {1'b0, 4'hC};
      7'b1001111: d = {1'b0, 4'hE};
      7'b1000111: d = {1'b0, 4'hF};
      default:    d = {1'b1, 4'h0};
    endcase
    return d;
  endfunction

  assign com_n_c = COM_ACT_LOW ? ~i_com : i_com;
  assign seg_n_c = SEG_ACT_LOW ? ~i_seg : i_seg;
  assign dp_n_c  = SEG_ACT_LOW ? ~i_dp  : i_dp;

  // Input register plus its previous value for the stability comparison
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      com_q <= '0; seg_q <= '0; dp_q <= 1'b0;
      com_p <= '0; seg_p <= '0; dp_p <= 1'b0;
    end else begin
      com_q <= com_n_c; seg_q <= seg_n_c; dp_q <= dp_n_c;
      com_p <= com_q;   seg_p <= seg_q;   dp_p <= dp_q;
    end
  end

  assign same_c   = ({com_q, seg_q, dp_q} == {com_p, seg_p, dp_p});
  assign sel_ok_c = $onehot(com_q);
  assign dec_c    = decode7(seg_q);
  assign load_c   = &seen;
  assign hs_c     = o_valid & i_ready;

  always_comb begin
    idx_c = '0;
    for (int unsigned k = 0; k < NDIG; k++)
      if (com_q[k]) idx_c = IDX_W'(k);
  end

  always_comb begin
    frame_c = '0;
    for (int unsigned k = 0; k < NDIG; k++)
      frame_c[k*CODE_W +: CODE_W] = slot_code[k];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SETTLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture fires on the cycle the stable count would reach STABLE_CNT-1
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_c   = 1'b0;
    case (state_q)
      SETTLE: begin
        if (same_c && sel_ok_c) begin
          if (cnt_q == CNT_CAP) begin
            cap_c   = 1'b1;
            cnt_d   = CNT_MAX;
            state_d = HOLD;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      HOLD: begin
        if (!same_c) begin
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = SETTLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen     <= '0;
      slot_dp  <= '0;
      slot_bad <= '0;
      for (int unsigned k = 0; k < NDIG; k++) slot_code[k] <= '0;
    end else begin
      if (load_c) seen <= '0;
      if (cap_c) begin
        slot_code[idx_c] <= dec_c[CODE_W-1:0];
        slot_bad[idx_c]  <= dec_c[CODE_W];
        slot_dp[idx_c]   <= dp_q;
        seen[idx_c]      <= 1'b1;
      end
    end
  end

  // A load while a frame is still pending and not being accepted flags an overrun
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_digits  <= '0;
      o_dp      <= '0;
      o_bad     <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else if (load_c) begin
      o_digits  <= frame_c;
      o_dp      <= slot_dp;
      o_bad     <= slot_bad;
      o_valid   <= 1'b1;
      o_overrun <= ~hs_c & (o_overrun | o_valid);
    end else if (hs_c) begin
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fnd_seg_capture.sv
// Bench for fnd_seg_capture: an active-high and an active-low instance share one stimulus,
// a run-length reference model predicts frames, a monitor checks them at each handshake.
module tb_fnd_seg_capture;

  localparam int STABLE = 4;

  typedef struct packed {
    logic [23:0] digits;
    logic [5:0]  dp;
    logic [5:0]  bad;
    logic        ovr;
  } frame_t;

  localparam logic [6:0] TSEG [14] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                       7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                       7'b1111111, 7'b1110011, 7'b1110111, 7'b1001110,
                                       7'b1001111, 7'b1000111};
  localparam logic [3:0] TCODE [14] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                                        4'h8, 4'h9, 4'hA, 4'hC, 4'hE, 4'hF};

  logic        clk = 1'b0;
  logic        rst_n, i_ready, dp;
  logic [5:0]  com;
  logic [6:0]  seg;
  logic [5:0]  com_inv;
  logic [6:0]  seg_inv;
  logic        dp_inv;
  logic [23:0] a_digits, b_digits;
  logic [5:0]  a_dp, b_dp, a_bad, b_bad;
  logic        a_valid, b_valid, a_overrun, b_overrun;

  assign com_inv = ~com;
  assign seg_inv = ~seg;
  assign dp_inv  = ~dp;

  fnd_seg_capture #(.STABLE_CNT(STABLE), .COM_ACT_LOW(1'b0), .SEG_ACT_LOW(1'b0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_com(com), .i_seg(seg), .i_dp(dp),
    .o_digits(a_digits), .o_dp(a_dp), .o_bad(a_bad), .o_valid(a_valid),
    .i_ready(i_ready), .o_overrun(a_overrun));

  fnd_seg_capture #(.STABLE_CNT(STABLE), .COM_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_com(com_inv), .i_seg(seg_inv), .i_dp(dp_inv),
    .o_digits(b_digits), .o_dp(b_dp), .o_bad(b_bad), .o_valid(b_valid),
    .i_ready(i_ready), .o_overrun(b_overrun));

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  bit     started = 1'b0;
  bit     rnd_rdy = 1'b0;
  frame_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    for (int i = 0; i < 14; i++)
      if (TSEG[i] == s) return {1'b0, TCODE[i]};
    return 5'b10000;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] c);
    for (int i = 0; i < 14; i++)
      if (TCODE[i] == c) return TSEG[i];
    return 7'b0;
  endfunction

  function automatic logic [3:0] rand_code();
    return TCODE[$urandom_range(0, 13)];
  endfunction

  // Reference model: a capture happens once per run of >= STABLE identical one-hot samples
  logic [13:0] run_val, m_smp;
  int          run_len, m_idx;
  logic [3:0]  m_code [6];
  logic [5:0]  m_dp, m_bad, m_seen;
  logic [4:0]  m_dec;
  bit          pend_m, vld_m, m_hs;
  frame_t      pend_frame, last_m, m_f;

  always @(posedge clk) begin
    m_smp = {com, seg, dp};
    if (!rst_n) begin
      started = 1'b1;
      m_seen  = '0;
      pend_m  = 1'b0;
      vld_m   = 1'b0;
      last_m  = '0;
      exp_q.delete();
      run_val = '0;
      run_len = 1;
    end else begin
      m_hs = vld_m && i_ready;
      if (pend_m) begin
        m_f = pend_frame;
        if (vld_m && !m_hs) begin
          m_f.ovr = 1'b1;
          if (exp_q.size() > 0) exp_q[exp_q.size()-1] = m_f;
          else exp_q.push_back(m_f);
        end else begin
          exp_q.push_back(m_f);
        end
        last_m = m_f;
        vld_m  = 1'b1;
        pend_m = 1'b0;
      end else if (m_hs) begin
        vld_m = 1'b0;
      end
      if (run_len == STABLE && $onehot(run_val[13:8])) begin
        m_idx = 0;
        for (int k = 0; k < 6; k++) if (run_val[8+k]) m_idx = k;
        m_dec = ref_decode(run_val[7:1]);
        m_code[m_idx] = m_dec[3:0];
        m_bad[m_idx]  = m_dec[4];
        m_dp[m_idx]   = run_val[0];
        m_seen[m_idx] = 1'b1;
        if (&m_seen) begin
          for (int k = 0; k < 6; k++) pend_frame.digits[4*k +: 4] = m_code[k];
          pend_frame.dp  = m_dp;
          pend_frame.bad = m_bad;
          pend_frame.ovr = 1'b0;
          pend_m = 1'b1;
          m_seen = '0;
        end
      end
      if (m_smp == run_val) run_len++;
      else begin
        run_val = m_smp;
        run_len = 1;
      end
    end
  end

  // Monitor: valid tracking every cycle, held outputs while idle, frame compare on handshake
  frame_t mon_e;
  always @(negedge clk) begin
    if (started) begin
      chk("valid_a", 32'(a_valid), 32'(vld_m));
      chk("valid_b", 32'(b_valid), 32'(vld_m));
      if (!vld_m) begin
        chk("idle_digits_a", 32'(a_digits), 32'(last_m.digits));
        chk("idle_digits_b", 32'(b_digits), 32'(last_m.digits));
        chk("idle_dp_a", 32'(a_dp), 32'(last_m.dp));
        chk("idle_bad_a", 32'(a_bad), 32'(last_m.bad));
        chk("idle_overrun_a", 32'(a_overrun), 32'd0);
        chk("idle_overrun_b", 32'(b_overrun), 32'd0);
      end
      if (a_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame actual=%0h expected=none t=%0t", a_digits, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("frame_digits_a", 32'(a_digits), 32'(mon_e.digits));
          chk("frame_digits_b", 32'(b_digits), 32'(mon_e.digits));
          chk("frame_dp_a", 32'(a_dp), 32'(mon_e.dp));
          chk("frame_dp_b", 32'(b_dp), 32'(mon_e.dp));
          chk("frame_bad_a", 32'(a_bad), 32'(mon_e.bad));
          chk("frame_bad_b", 32'(b_bad), 32'(mon_e.bad));
          chk("frame_overrun_a", 32'(a_overrun), 32'(mon_e.ovr));
          chk("frame_overrun_b", 32'(b_overrun), 32'(mon_e.ovr));
        end
      end
    end
  end

  task automatic hold_bus(input int n);
    for (int i = 0; i < n; i++) begin
      if (rnd_rdy) i_ready = 1'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    com = '0; seg = '0; dp = 1'b0;
    hold_bus(n);
  endtask

  task automatic send_digit(input int k, input logic [6:0] s, input logic d, input int n);
    com = 6'(1 << k); seg = s; dp = d;
    hold_bus(n);
  endtask

  task automatic send_frame(input logic [23:0] codes, input logic [5:0] dps, input int hold);
    for (int k = 0; k < 6; k++) send_digit(k, seg_of(codes[4*k +: 4]), dps[k], hold);
    idle(2);
  endtask

  task automatic pulse_ready();
    i_ready = 1'b1;
    hold_bus(1);
    i_ready = 1'b0;
    hold_bus(2);
  endtask

  function automatic logic [23:0] rand_frame();
    logic [23:0] c;
    for (int k = 0; k < 6; k++) c[4*k +: 4] = rand_code();
    return c;
  endfunction

  initial begin
    logic [3:0] ca, cb;
    int t;
    rst_n = 1'b0; i_ready = 1'b0; com = '0; seg = '0; dp = 1'b0;
    for (int i = 0; i < 2; i++) begin
      com = 6'($urandom); seg = 7'($urandom); dp = 1'($urandom);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    idle(10);

    // Plain frame 1..6
    send_frame(24'h654321, 6'b000000, 8);
    idle(4);
    pulse_ready();

    // Toggling digit 2, then a 3-cycle (no capture) and 4-cycle (capture) digit 5
    ca = rand_code();
    cb = TCODE[($urandom_range(0, 13) + 1) % 14];
    if (cb == ca) cb = (ca == 4'h8) ? 4'h1 : 4'h8;
    send_digit(0, seg_of(rand_code()), 1'b0, 8);
    send_digit(1, seg_of(rand_code()), 1'b1, 8);
    for (int i = 0; i < 10; i++) send_digit(2, seg_of((i % 2 == 0) ? ca : cb), 1'b0, 2);
    send_digit(2, seg_of(rand_code()), 1'b0, 8);
    send_digit(3, seg_of(rand_code()), 1'b0, 8);
    send_digit(4, seg_of(rand_code()), 1'b1, 8);
    send_digit(5, seg_of(rand_code()), 1'b0, 3);
    idle(10);
    send_digit(5, seg_of(rand_code()), 1'b1, 4);
    idle(4);
    pulse_ready();

    // Non-one-hot selects never capture
    for (int k = 0; k < 5; k++) send_digit(k, seg_of(rand_code()), 1'($urandom), 8);
    com = 6'b010101; seg = seg_of(rand_code()); hold_bus(50);
    com = 6'b000000; seg = seg_of(rand_code()); hold_bus(50);
    com = 6'b110000; seg = seg_of(rand_code()); hold_bus(20);
    send_digit(5, seg_of(rand_code()), 1'b0, 8);
    idle(4);
    pulse_ready();

    // Undecodable pattern on digit 3, code 6 with dp on digit 4
    send_digit(0, seg_of(4'h9), 1'b0, 6);
    send_digit(1, seg_of(4'hA), 1'b0, 6);
    send_digit(2, seg_of(4'hF), 1'b0, 6);
    send_digit(3, 7'b0000001, 1'b0, 6);
    send_digit(4, 7'b1011111, 1'b1, 6);
    send_digit(5, seg_of(4'hC), 1'b0, 6);
    idle(4);
    pulse_ready();

    // Overrun, then a load coinciding with a handshake
    send_frame(rand_frame(), 6'($urandom), 6);
    send_frame(rand_frame(), 6'($urandom), 6);
    pulse_ready();
    send_frame(rand_frame(), 6'($urandom), 5);
    for (int k = 0; k < 5; k++) send_digit(k, seg_of(rand_code()), 1'($urandom), 6);
    com = 6'b100000; seg = seg_of(rand_code()); dp = 1'b1;
    t = 0;
    while (!pend_m && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("load_wait", 32'(pend_m), 32'd1);
    i_ready = 1'b1;
    hold_bus(1);
    i_ready = 1'b0;
    idle(4);
    pulse_ready();

    // Reset mid-frame discards partial digits
    for (int k = 0; k < 3; k++) send_digit(k, seg_of(rand_code()), 1'b1, 6);
    rst_n = 1'b0;
    hold_bus(2);
    rst_n = 1'b1;
    for (int k = 3; k < 6; k++) send_digit(k, seg_of(rand_code()), 1'b0, 6);
    idle(6);
    for (int k = 0; k < 3; k++) send_digit(k, seg_of(rand_code()), 1'b0, 6);
    idle(4);
    pulse_ready();

    // Random frames with glitches and a random consumer
    rnd_rdy = 1'b1;
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < 6; k++) begin
        if ($urandom_range(0, 9) < 3) begin
          com = 6'($urandom); seg = 7'($urandom); dp = 1'($urandom);
          hold_bus($urandom_range(1, 3));
        end
        send_digit(k, ($urandom_range(0, 9) == 0) ? 7'($urandom) : seg_of(rand_code()),
                   1'($urandom), $urandom_range(3, 9));
      end
    end

    // Random bus soup
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0:       com = 6'($urandom);
        1:       com = 6'b000000;
        default: com = 6'(1 << $urandom_range(0, 5));
      endcase
      seg = ($urandom_range(0, 3) == 0) ? 7'($urandom) : seg_of(rand_code());
      dp = 1'($urandom);
      hold_bus($urandom_range(1, 7));
    end

    rnd_rdy = 1'b0;
    i_ready = 1'b1;
    idle(20);
    i_ready = 1'b0;
    idle(3);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
